// File: rtl/btn_debounce_pulse.sv
// ============================================================================
// Module   : btn_debounce_pulse
// Purpose  : Per-button synchroniser, debouncer, press/release edge strobes and
//            auto-repeating load strobe for the board push-buttons.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce_pulse #(
  parameter int            N          = 5,
  parameter int            DB_CYCLES  = 1000000,
  parameter int            RPT_DELAY  = 50000000,
  parameter int            RPT_PERIOD = 10000000,
  parameter logic [N-1:0]  RPT_EN     = '0
) (
  input  logic         CLK100MHZ,
  input  logic         CPU_RESETN,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic [N-1:0] btn_pulse
);

  localparam int c_DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int c_RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int c_RPT_W   = (c_RPT_MAX > 1) ? $clog2(c_RPT_MAX) : 1;

  localparam logic [c_DB_W-1:0]  c_DB_TC  = c_DB_W'(DB_CYCLES - 1);
  localparam logic [c_DB_W-1:0]  c_DB_ONE = c_DB_W'(1);
  localparam logic [c_RPT_W-1:0] c_DLY_TC  = c_RPT_W'(RPT_DELAY - 1);
  localparam logic [c_RPT_W-1:0] c_PER_TC  = c_RPT_W'(RPT_PERIOD - 1);
  localparam logic [c_RPT_W-1:0] c_RPT_ONE = c_RPT_W'(1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DELAY  = 2'd1;
  localparam logic [1:0] c_REPEAT = 2'd2;

  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_bit
    logic               r_stable;
    logic               r_stable_d;
    logic [c_DB_W-1:0]  r_db_cnt;
    logic [1:0]         r_state;
    logic [c_RPT_W-1:0] r_rpt_cnt;
    logic               w_press;
    logic               w_rpt;

    // Any cycle where the synchronised input agrees with the stable level restarts the count.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        r_stable   <= 1'b0;
        r_stable_d <= 1'b0;
        r_db_cnt   <= '0;
      end else begin
        r_stable_d <= r_stable;
        if (r_sync2[i] == r_stable) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_TC) begin
          r_stable <= r_sync2[i];
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + c_DB_ONE;
        end
      end
    end

    assign w_press = r_stable & ~r_stable_d;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        r_state   <= c_IDLE;
        r_rpt_cnt <= '0;
      end else begin
        case (r_state)
          c_IDLE: begin
            if (w_press && RPT_EN[i]) begin
              r_state   <= c_DELAY;
              r_rpt_cnt <= '0;
            end
          end
          c_DELAY: begin
            if (!r_stable) begin
              r_state   <= c_IDLE;
              r_rpt_cnt <= '0;
            end else if (r_rpt_cnt == c_DLY_TC) begin
              r_state   <= c_REPEAT;
              r_rpt_cnt <= '0;
            end else begin
              r_rpt_cnt <= r_rpt_cnt + c_RPT_ONE;
            end
          end
          c_REPEAT: begin
            if (!r_stable) begin
              r_state   <= c_IDLE;
              r_rpt_cnt <= '0;
            end else if (r_rpt_cnt == c_PER_TC) begin
              r_rpt_cnt <= '0;
            end else begin
              r_rpt_cnt <= r_rpt_cnt + c_RPT_ONE;
            end
          end
          default: begin
            r_state   <= c_IDLE;
            r_rpt_cnt <= '0;
          end
        endcase
      end
    end

    // Gating on the level makes a release win over a coincident terminal count.
    assign w_rpt = r_stable &&
                   (((r_state == c_DELAY)  && (r_rpt_cnt == c_DLY_TC)) ||
                    ((r_state == c_REPEAT) && (r_rpt_cnt == c_PER_TC)));

    assign btn_level[i]   = r_stable;
    assign btn_press[i]   = w_press;
    assign btn_release[i] = ~r_stable & r_stable_d;
    assign btn_pulse[i]   = w_press | w_rpt;
  end

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce_pulse.sv
// ============================================================================
// Module   : tb_btn_debounce_pulse
// Purpose  : Scoreboard bench for btn_debounce_pulse with short timing params.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_debounce_pulse;

  typedef struct {
    int         at;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] pulse;
    logic [1:0] level;
  } ev_t;

  logic       CLK100MHZ = 1'b0;
  logic       CPU_RESETN = 1'b0;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_pulse;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t q[$];

  btn_debounce_pulse #(
    .N          (2),
    .DB_CYCLES  (4),
    .RPT_DELAY  (8),
    .RPT_PERIOD (3),
    .RPT_EN     (2'b10)
  ) dut (
    .CLK100MHZ   (CLK100MHZ),
    .CPU_RESETN  (CPU_RESETN),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_pulse   (btn_pulse)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;
  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  function automatic void expect_ev(int at, logic [1:0] p, logic [1:0] r,
                                    logic [1:0] pu, logic [1:0] l);
    ev_t e;
    e.at = at; e.press = p; e.rel = r; e.pulse = pu; e.level = l;
    q.push_back(e);
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  task automatic check_out(string name, logic [7:0] exp);
    logic [7:0] act;
    act = {btn_level, btn_press, btn_release, btn_pulse};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d lvl/prs/rel/pls actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  // Monitor: any strobe must match the oldest expected event, in the expected cycle.
  always @(negedge CLK100MHZ) begin
    ev_t e;
    while (q.size() > 0 && q[0].at < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event expected at cyc=%0d (now %0d) pls=%b prs=%b rel=%b", e.at, cyc, e.pulse, e.press, e.rel);
    end
    if ((btn_press | btn_release | btn_pulse) != 2'b00) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe cyc=%0d actual prs=%b rel=%b pls=%b required none", cyc, btn_press, btn_release, btn_pulse);
      end else begin
        e = q.pop_front();
        if (e.at != cyc || btn_press !== e.press || btn_release !== e.rel ||
            btn_pulse !== e.pulse || btn_level !== e.level) begin
          errors++;
          $display("FAIL strobe_event actual cyc=%0d prs=%b rel=%b pls=%b lvl=%b required cyc=%0d prs=%b rel=%b pls=%b lvl=%b",
                   cyc, btn_press, btn_release, btn_pulse, btn_level,
                   e.at, e.press, e.rel, e.pulse, e.level);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int r;

    step(3);
    check_out("reset_state", 8'h00);
    CPU_RESETN = 1'b1;
    step(3);
    check_out("idle_after_reset", 8'h00);

    // Single press/release on a non-repeating button.
    t = cyc;
    btn_raw[0] = 1'b1;
    expect_ev(t + 6, 2'b01, 2'b00, 2'b01, 2'b01);
    step(10);
    check_out("held_level_bit0", {2'b01, 6'b0});
    step(10);
    btn_raw[0] = 1'b0;
    expect_ev(t + 26, 2'b00, 2'b01, 2'b00, 2'b00);
    step(12);
    check_out("released_level_bit0", 8'h00);

    // Bouncing input never settles for DB_CYCLES.
    for (int k = 0; k < 12; k++) begin
      btn_raw[0] = ~btn_raw[0];
      step(2);
    end
    btn_raw = 2'b00;
    step(10);
    check_out("bounce_no_level", 8'h00);

    // Both held; release lands on bit 1's terminal count and must suppress it.
    t = cyc;
    btn_raw = 2'b11;
    expect_ev(t + 6, 2'b11, 2'b00, 2'b11, 2'b11);
    for (int s = t + 14; s < t + 47; s += 3)
      expect_ev(s, 2'b00, 2'b00, 2'b10, 2'b11);
    step(10);
    check_out("held_level_both", {2'b11, 6'b0});
    step(31);
    btn_raw = 2'b00;
    expect_ev(t + 47, 2'b00, 2'b11, 2'b00, 2'b00);
    step(20);
    check_out("idle_after_release", 8'h00);

    // Staggered presses, then reset while bit 1 is repeating.
    t = cyc;
    btn_raw[0] = 1'b1;
    step(1);
    btn_raw[1] = 1'b1;
    expect_ev(t + 6, 2'b01, 2'b00, 2'b01, 2'b01);
    expect_ev(t + 7, 2'b10, 2'b00, 2'b10, 2'b11);
    expect_ev(t + 15, 2'b00, 2'b00, 2'b10, 2'b11);
    expect_ev(t + 18, 2'b00, 2'b00, 2'b10, 2'b11);
    step(19);
    CPU_RESETN = 1'b0;
    #1;
    check_out("async_reset_clears", 8'h00);
    step(3);
    check_out("held_in_reset", 8'h00);

    // Buttons still down at reset release count as a fresh press.
    CPU_RESETN = 1'b1;
    r = cyc;
    expect_ev(r + 6, 2'b11, 2'b00, 2'b11, 2'b11);
    for (int s = r + 14; s < r + 25; s += 3)
      expect_ev(s, 2'b00, 2'b00, 2'b10, 2'b11);
    step(5);
    check_out("no_level_before_db", 8'h00);
    step(14);
    btn_raw = 2'b00;
    expect_ev(r + 25, 2'b00, 2'b11, 2'b00, 2'b00);
    step(15);
    check_out("final_idle", 8'h00);

    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event expected at cyc=%0d pls=%b never seen", e.at, e.pulse);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
